// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions for the KGP decode stage: opcodes, control-word layout,
// FSM state type and the pure instruction decode function.
package kgp_decode_pkg;

    localparam int OPC_W  = 6;
    localparam int FN_W   = 5;
    localparam int CTRL_W = 16;

    localparam logic [OPC_W-1:0] OP_RTYPE  = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADDI   = 6'b001000;
    localparam logic [OPC_W-1:0] OP_LD     = 6'b010000;
    localparam logic [OPC_W-1:0] OP_ST     = 6'b010001;
    localparam logic [2:0]       OP_BR_PFX = 3'b011;
    localparam logic [OPC_W-1:0] OP_CALL   = 6'b100000;

    // Control word, MSB first: SA, SB[1:0], ALUOP[2:0], DIFF, SC[2:0], WA, WB, WR, SSW, SS, SPC
    localparam int CW_SA    = 15;
    localparam int CW_SB    = 13;
    localparam int CW_ALUOP = 10;
    localparam int CW_DIFF  = 9;
    localparam int CW_SC    = 6;
    localparam int CW_WA    = 5;
    localparam int CW_WB    = 4;
    localparam int CW_WR    = 3;
    localparam int CW_SSW   = 2;
    localparam int CW_SS    = 1;
    localparam int CW_SPC   = 0;

    // CALL micro-ops: link write, then the jump
    localparam logic [CTRL_W-1:0] CTRL_CALL_UOP0 = (16'b010 << CW_SC) | (16'b1 << CW_WR);
    localparam logic [CTRL_W-1:0] CTRL_CALL_UOP1 = (16'b1 << CW_SPC) | (16'b1 << CW_SSW);

    typedef enum logic {IDLE, SECOND} state_e;

    typedef struct packed {
        logic              illegal;
        logic [CTRL_W-1:0] ctrl;
    } dec_t;

    function automatic dec_t decode(input logic [OPC_W-1:0] op, input logic [FN_W-1:0] funct);
        dec_t d;
        d = '0;
        if (op == OP_RTYPE) begin
            d.ctrl[CW_WR]            = 1'b1;
            d.ctrl[CW_ALUOP +: 3]    = funct[2:0];
            d.ctrl[CW_DIFF]          = funct[3];
        end else if (op == OP_ADDI) begin
            d.ctrl[CW_ALUOP +: 3]    = 3'b001;
            d.ctrl[CW_WR]            = 1'b1;
        end else if (op == OP_LD) begin
            d.ctrl[CW_SB +: 2]       = 2'b01;
            d.ctrl[CW_ALUOP +: 3]    = 3'b001;
            d.ctrl[CW_SC +: 3]       = 3'b001;
            d.ctrl[CW_WR]            = 1'b1;
        end else if (op == OP_ST) begin
            d.ctrl[CW_SB +: 2]       = 2'b01;
            d.ctrl[CW_ALUOP +: 3]    = 3'b001;
            d.ctrl[CW_WB]            = 1'b1;
        end else if (op[5:3] == OP_BR_PFX) begin
            d.ctrl[CW_SS]            = 1'b1;
            d.ctrl[CW_SPC]           = 1'b1;
            d.ctrl[CW_SB +: 2]       = 2'b10;
            d.ctrl[CW_ALUOP +: 3]    = op[2:0];
        end else if (op == OP_CALL) begin
            d.ctrl = CTRL_CALL_UOP0;
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage; slave = decode stage.
interface instr_decode_stage_if
    import kgp_decode_pkg::*;
#(
    parameter int INSTR_W = 32
) ();
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  out_ctrl;
    logic               out_uop;
    logic               out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_ctrl, out_uop, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_ctrl, out_uop, out_illegal
    );
endinterface

// File: rtl/instr_decode_stage_fifo.sv
// decode_fifo: DEPTH-entry circular buffer with synchronous clear; head is zero while empty.
module decode_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 18,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_i && !rst && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
endmodule

// File: rtl/instr_decode_stage.sv
// KGP decode stage: instruction -> 16-bit control word, CALL split into two micro-ops.
// Optional feature macro DECODE_ILLEGAL_TRAP_EN: flag illegal opcodes and stall until flush/rst.
module instr_decode_stage
    import kgp_decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 5,
    parameter int DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    instr_decode_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic              trap_q;
    logic [CNT_W-1:0]  count;
    logic              fifo_valid;
    logic [CTRL_W+1:0] head;
    logic              push;
    logic [CTRL_W+1:0] push_data;
    logic              pop;
    logic              accept;
    logic [OP_W-1:0]   op;
    dec_t              dec;

    assign op  = bus.in_instr[INSTR_W-1 -: OP_W];
    assign dec = decode(op, bus.in_instr[FUNCT_W-1:0]);

    assign bus.in_ready = !rst && (state_q == IDLE) && (count < DEPTH_C) && !trap_q;
    assign accept       = bus.in_valid && bus.in_ready && !flush;
    assign pop          = fifo_valid && bus.out_ready;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    push = 1'b1;
                    if (op == OP_CALL) begin
                        push_data = {1'b0, 1'b0, CTRL_CALL_UOP0};
                        state_d   = SECOND;
                    end else begin
                        push_data = {dec.illegal & TRAP_EN, 1'b0, dec.ctrl};
                    end
                end
            end
            SECOND: begin
                // A dequeue in the same cycle frees the slot uop1 needs
                if (count < DEPTH_C || pop) begin
                    push      = 1'b1;
                    push_data = {1'b0, 1'b1, CTRL_CALL_UOP1};
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            push    = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)                         trap_q <= 1'b0;
        else if (TRAP_EN && accept && dec.illegal) trap_q <= 1'b1;
    end

    decode_fifo #(
        .DEPTH (DEPTH),
        .W     (CTRL_W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.out_valid   = fifo_valid;
    assign bus.out_ctrl    = head[CTRL_W-1:0];
    assign bus.out_uop     = head[CTRL_W];
    assign bus.out_illegal = head[CTRL_W+1];
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: table of single-uop decodes plus CALL/backpressure/flush/rst/illegal sequences.
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic rst, flush;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    instr_decode_stage_if #(.INSTR_W(32)) dif ();

    instr_decode_stage #(.INSTR_W(32), .OP_W(6), .FUNCT_W(5), .DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (dif.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [15:0] ctrl;
    } vec_t;
    vec_t vecs[7];

    logic [17:0] obs[$];
    always @(posedge clk)
        if (!rst && dif.out_valid && dif.out_ready)
            obs.push_back({dif.out_illegal, dif.out_uop, dif.out_ctrl});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string nm, input logic [31:0] ins);
        int n = 0;
        bit ok;
        dif.in_valid = 1'b1;
        dif.in_instr = ins;
        do begin
            ok = dif.in_ready;
            step();
            n++;
        end while (!ok && n < 32);
        dif.in_valid = 1'b0;
        chk({nm, "_accepted"}, 32'(ok), 32'd1);
    endtask

    task automatic chk_head(input string nm, input logic [15:0] c, input logic u, input logic il);
        chk({nm, "_valid"}, 32'(dif.out_valid), 32'd1);
        chk({nm, "_ctrl"}, 32'(dif.out_ctrl), 32'(c));
        chk({nm, "_uop"}, 32'(dif.out_uop), 32'(u));
        chk({nm, "_illegal"}, 32'(dif.out_illegal), 32'(il));
    endtask

    localparam logic [31:0] I_ADDI = 32'h2000_0000;
    localparam logic [31:0] I_LD   = 32'h4000_0000;
    localparam logic [31:0] I_ST   = 32'h4400_0000;
    localparam logic [31:0] I_CALL = 32'h8000_0000;
    localparam logic [15:0] C_ADDI = 16'h0408;
    localparam logic [15:0] C_LD   = 16'h2448;
    localparam logic [15:0] C_ST   = 16'h2410;
    localparam logic [15:0] C_U0   = 16'h0088;
    localparam logic [15:0] C_U1   = 16'h0005;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"addi",   I_ADDI,        C_ADDI};
        vecs[1] = '{"ld",     I_LD,          C_LD};
        vecs[2] = '{"st",     I_ST,          C_ST};
        vecs[3] = '{"br101",  32'h7400_0000, 16'h5403};
        vecs[4] = '{"br000",  32'h6000_0000, 16'h4003};
        vecs[5] = '{"r_0d",   32'h0000_000D, 16'h1608};
        vecs[6] = '{"r_02",   32'h0000_0002, 16'h0808};

        rst = 1'b1; flush = 1'b0;
        dif.in_valid = 1'b0; dif.in_instr = '0; dif.out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", 32'(dif.in_ready), 32'd0);
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_out_ctrl", 32'(dif.out_ctrl), 32'd0);
        chk("rst_out_uop", 32'(dif.out_uop), 32'd0);
        chk("rst_out_illegal", 32'(dif.out_illegal), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(dif.in_ready), 32'd1);

        // Table: one instruction per cycle with execute always ready
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].name, vecs[i].instr);
            chk_head(vecs[i].name, vecs[i].ctrl, 1'b0, 1'b0);
        end
        step();
        chk("table_drained", 32'(dif.out_valid), 32'd0);

        // Backpressure: two fill the FIFO, third waits for a dequeue
        obs.delete();
        dif.out_ready = 1'b0;
        send("bp0", I_LD);
        send("bp1", I_ST);
        chk("bp_full_in_ready", 32'(dif.in_ready), 32'd0);
        step(); step();
        chk("bp_hold_in_ready", 32'(dif.in_ready), 32'd0);
        chk_head("bp_hold_head", C_LD, 1'b0, 1'b0);
        dif.out_ready = 1'b1;
        send("bp2", I_ADDI);
        step(); step(); step();
        chk("bp_obs_n", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("bp_obs0", 32'(obs[0]), 32'({2'b00, C_LD}));
            chk("bp_obs1", 32'(obs[1]), 32'({2'b00, C_ST}));
            chk("bp_obs2", 32'(obs[2]), 32'({2'b00, C_ADDI}));
        end

        // CALL with a free-running consumer
        send("call", I_CALL);
        chk("call_stall", 32'(dif.in_ready), 32'd0);
        chk_head("call_u0", C_U0, 1'b0, 1'b0);
        step();
        chk("call_resume", 32'(dif.in_ready), 32'd1);
        chk_head("call_u1", C_U1, 1'b1, 1'b0);
        step();
        chk("call_drained", 32'(dif.out_valid), 32'd0);

        // CALL into a FIFO with one free slot: uop1 waits for a dequeue
        obs.delete();
        dif.out_ready = 1'b0;
        send("c2_pre", I_ADDI);
        send("c2_call", I_CALL);
        for (int k = 0; k < 3; k++) begin
            chk("c2_hold_in_ready", 32'(dif.in_ready), 32'd0);
            chk_head("c2_hold_head", C_ADDI, 1'b0, 1'b0);
            step();
        end
        dif.out_ready = 1'b1;
        step(); step(); step();
        chk("c2_in_ready", 32'(dif.in_ready), 32'd1);
        chk("c2_obs_n", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("c2_obs0", 32'(obs[0]), 32'({2'b00, C_ADDI}));
            chk("c2_obs1", 32'(obs[1]), 32'({2'b00, C_U0}));
            chk("c2_obs2", 32'(obs[2]), 32'({2'b01, C_U1}));
        end

        // Flush in SECOND with a full FIFO
        obs.delete();
        dif.out_ready = 1'b0;
        send("fl_pre", I_ADDI);
        send("fl_call", I_CALL);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_out_valid", 32'(dif.out_valid), 32'd0);
        chk("fl_in_ready", 32'(dif.in_ready), 32'd1);
        chk("fl_out_ctrl", 32'(dif.out_ctrl), 32'd0);
        dif.out_ready = 1'b1;
        step(); step(); step();
        chk("fl_no_uop1", obs.size(), 0);

        // Reset in SECOND with a full FIFO
        dif.out_ready = 1'b0;
        send("rs_pre", I_LD);
        send("rs_call", I_CALL);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rs_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rs_in_ready", 32'(dif.in_ready), 32'd1);
        dif.out_ready = 1'b1;
        step(); step(); step();
        chk("rs_no_uop", obs.size(), 0);

        // Illegal opcode 111111
        send("ill", 32'hFC00_0000);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk_head("ill", 16'h0000, 1'b0, 1'b1);
        step(); step(); step();
        chk("ill_stuck", 32'(dif.in_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ill_released", 32'(dif.in_ready), 32'd1);
`else
        chk_head("ill", 16'h0000, 1'b0, 1'b0);
        chk("ill_no_stall", 32'(dif.in_ready), 32'd1);
        step(); step();
        chk("ill_still_ready", 32'(dif.in_ready), 32'd1);
`endif
        send("after_ill", I_ADDI);
        chk_head("after_ill", C_ADDI, 1'b0, 1'b0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
